// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage sitting directly in front of instruction_memory.
// Holds the program counter, drives the memory address combinationally from
// the PC register, and captures the returned instruction into the IF/ID
// pipeline register together with its PC, PC+4 and a valid bit.
//
// Edge priority: reset > redirect_valid > stall > normal advance.
//
// Optional feature macro: FETCH_COUNTERS_EN
//   defined     -> fetch_count / bubble_count are live saturating counters
//   not defined -> both ports are tied to 0 and no counter state exists
//
// Ports
//   clk               in   system clock, rising edge
//   reset             in   synchronous active-high reset
//   imem_address      out  current PC, to instruction_memory.address
//   imem_instruction  in   combinational read data from instruction_memory
//   stall             in   hold PC and IF/ID contents
//   redirect_valid    in   taken branch/jump, load redirect_target
//   redirect_target   in   new PC (low two bits dropped)
//   if_id_valid       out  IF/ID holds a real instruction
//   if_id_pc          out  PC of captured instruction
//   if_id_pc_plus4    out  if_id_pc + 4
//   if_id_instruction out  captured instruction word
//   misalign_fault    out  one-cycle pulse after a non word-aligned redirect
//   fetch_count       out  number of valid captures
//   bubble_count      out  number of bubble loads plus stall holds
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instruction,
  output logic        misalign_fault,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
);

  logic [31:0] pc_q;
  logic        valid_q;
  logic [31:0] id_pc_q;
  logic [31:0] id_pc_plus4_q;
  logic [31:0] id_instr_q;
  logic        fault_q;

  assign imem_address      = pc_q;
  assign if_id_valid       = valid_q;
  assign if_id_pc          = id_pc_q;
  assign if_id_pc_plus4    = id_pc_plus4_q;
  assign if_id_instruction = id_instr_q;
  assign misalign_fault    = fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      valid_q       <= 1'b0;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
      id_instr_q    <= '0;
      fault_q       <= 1'b0;
    end else if (redirect_valid) begin
      // Redirect overrides stall; the word on imem_instruction is dropped.
      pc_q          <= {redirect_target[31:2], 2'b00};
      valid_q       <= 1'b0;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
      id_instr_q    <= '0;
      fault_q       <= |redirect_target[1:0];
    end else if (stall) begin
      fault_q       <= 1'b0;
    end else begin
      pc_q          <= pc_q + 32'd4;
      valid_q       <= 1'b1;
      id_pc_q       <= pc_q;
      id_pc_plus4_q <= pc_q + 32'd4;
      id_instr_q    <= imem_instruction;
      fault_q       <= 1'b0;
    end
  end

`ifdef FETCH_COUNTERS_EN
  logic [31:0] fetch_count_q;
  logic [31:0] bubble_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q  <= '0;
      bubble_count_q <= '0;
    end else if (redirect_valid || stall) begin
      if (bubble_count_q != 32'hFFFF_FFFF) begin
        bubble_count_q <= bubble_count_q + 32'd1;
      end
    end else begin
      if (fetch_count_q != 32'hFFFF_FFFF) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
    end
  end

  assign fetch_count  = fetch_count_q;
  assign bubble_count = bubble_count_q;
`else
  assign fetch_count  = '0;
  assign bubble_count = '0;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage placed directly upstream of `instruction_memory`. It holds the program counter, drives the memory's combinational `address` input, and captures the returned `instruction` into the IF/ID pipeline register. The captured value is presented with a valid bit to the decode stage. The block supports a stall from downstream hazard logic and a redirect from the branch/jump resolution logic.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_address`  out  32  connects to `instruction_memory.address`; equals current PC.
- `imem_instruction`  in  32  connects to `instruction_memory.instruction`; combinational read data.
- `stall`  in  1  hold PC and IF/ID contents.
- `redirect_valid`  in  1  taken branch or jump; load new PC.
- `redirect_target`  in  32  new PC when `redirect_valid` is high.
- `if_id_valid`  out  1  IF/ID register holds a real instruction.
- `if_id_pc`  out  32  PC of the captured instruction.
- `if_id_pc_plus4`  out  32  `if_id_pc + 4`, mod 2^32.
- `if_id_instruction`  out  32  captured instruction word.
- `misalign_fault`  out  1  one-cycle pulse: last redirect target was not word-aligned.
- `fetch_count`  out  32  count of instructions captured with valid=1. See Configuration.
- `bubble_count`  out  32  count of cycles in which the IF/ID register loaded a bubble or held during a stall. See Configuration.

## Operation
- Registered PC. `imem_address = pc` (combinational, no register between them).
- Per-edge priority: `reset` > `redirect_valid` > `stall` > normal advance.
- **Reset**:
  - `pc <= RESET_PC`.
  - `if_id_valid`, `if_id_pc`, `if_id_pc_plus4`, `if_id_instruction`, `misalign_fault`, `fetch_count`, `bubble_count` all `<= 0`.
- **Normal** (no reset, no redirect, no stall):
  - `pc <= pc + 4`; wraps from `32'hFFFF_FFFC` to `0`.
  - IF/ID loads `{valid=1, pc, pc+4, imem_instruction}`.
- **Stall** (no redirect): PC and all IF/ID fields hold their values.
- **Redirect** (regardless of `stall`):
  - `pc <= {redirect_target[31:2], 2'b00}`.
  - IF/ID loads a bubble: valid=0, pc/pc_plus4/instruction = 0.
  - The instruction currently on `imem_instruction` is discarded.
- **misalign_fault**: registered. It is 1 for exactly the one cycle after a redirect edge where `redirect_target[1:0] != 0`; otherwise 0.
- Back-to-back redirects: each one reloads the PC and inserts a bubble. The last one wins.
- Reset asserted mid-stall or mid-redirect: reset behaviour only.

## Timing
- Fetch latency: one edge. The instruction at address A appears on `if_id_instruction` in the cycle after the edge at which `pc == A` and the stage was not stalled.
- After reset is released, the first edge captures the instruction at `RESET_PC`. `if_id_valid` is 0 until that edge.
- Redirect penalty: one bubble cycle. With a redirect at edge N, the target instruction is in IF/ID after edge N+1, provided edge N+1 is not stalled.
- Throughput: one instruction per cycle when neither stalled nor redirected.
- No combinational path from `stall`, `redirect_*` or `imem_instruction` to any output other than through registers. `imem_address` depends on the PC register only.

## Configuration
- Macro: `FETCH_COUNTERS_EN`.
- **Defined**: `fetch_count` and `bubble_count` are live.
  - `fetch_count` increments on every edge that loads valid=1.
  - `bubble_count` increments on every edge that loads a bubble or holds because of a stall.
  - Both saturate at `32'hFFFF_FFFF` and are cleared by reset.
- **Not defined**: both ports are present but tied to constant 0, and no counter registers are synthesised.

## Test plan
The bench models memory as `imem_instruction = {16'hC0DE, imem_address[15:0]}`.
- **Reset then free-run.** Assert reset for 3 cycles, release, run 5 cycles. Required: `if_id_pc` = 0, 4, 8, 12, 16 on successive cycles with `if_id_instruction = 32'hC0DE_0000`, `..._0004`, and so on. `if_id_valid` = 0 during reset and 1 thereafter. All outputs = 0 while in reset.
- **Stall.** Assert `stall` for 3 cycles while `pc = 8`. Required: `imem_address` holds at 8; IF/ID holds `pc=4`, `instr=32'hC0DE_0004`. After release, `if_id_pc = 8` on the next edge.
- **Redirect.** At `pc = 0x10`, pulse `redirect_valid` with `redirect_target = 0x40`. Required: next cycle `imem_address = 0x40`, `if_id_valid = 0`. The cycle after that, `if_id_pc = 0x40`, `if_id_instruction = 32'hC0DE_0040`, `if_id_pc_plus4 = 0x44`.
- **Redirect and stall in the same cycle, target 0x80.** Required: redirect wins; `pc = 0x80` and a bubble is loaded.
- **Misaligned redirect, target 0x46.** Required: `pc = 0x44`; `misalign_fault` = 1 for exactly one cycle.
- **Wrap and counters.** Set `RESET_PC = 32'hFFFF_FFFC` and run 2 cycles. Required: `imem_address` goes `FFFF_FFFC` → `0000_0000`. With `FETCH_COUNTERS_EN` defined, after the stall scenario (3 stall cycles, 5 fetches), `fetch_count = 5` and `bubble_count = 3`. Without the macro, both read 0.
